dma_rx_burst: RTL

Parametrised serial-receive DMA engine. It drains up to NBYTES bytes from the serial RX FIFO and writes each byte into RAM at consecutive addresses starting at BASE_ADDR, after winning the system bus from the CPU. Compared with the fixed 3-byte engine, it adds:
- configurable burst length and buffer base;
- tolerance of bus-grant loss mid-burst;
- Ena freeze/resume;
- reporting of the bytes-written count and a partial-burst flag.

It sits between the serial RX FIFO, the RAM bus and the CPU bus arbiter.

---
 rtl/dma_rx_burst.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/dma_rx_burst.sv
// dma_rx_burst -- serial-receive DMA engine.
//
// Drains up to NBYTES bytes from the serial RX FIFO and writes them into RAM
// at BASE_ADDR, BASE_ADDR+1, ... (address wraps modulo 2**ADDR_W). The engine
// first wins the system bus from the CPU (Bus_req/Bus_grant) and holds the
// request for the whole burst. It survives loss of grant mid-burst and can
// be frozen with Ena. It reports the size of the last burst on Byte_Count
// and flags an early end on Dma_Partial.
//
// Handshake rules:
//   - Bus: Bus_req stays high from the first request until the burst ends.
//     A FIFO pop (Data_Read) or a RAM write (Cs/Wena) only happens in a
//     cycle where Bus_grant is high. Without grant the engine waits in place.
//   - FIFO: Data_Read is a one-cycle pop strobe. It is issued only after
//     RX_Empty has been seen low, in IDLE or in the previous WRITE. The popped
//     byte is presented on RX_Data from the cycle after the pop until the
//     next pop.
//
// Ports:
//   Clk, Rst_n     clock (rising edge), asynchronous active-low reset
//   Ena            engine enable; low freezes state and zeroes the strobes
//   RX_Data        FIFO output data (last popped byte)
//   RX_Full        FIFO full; reserved, not used
//   RX_Empty       FIFO empty
//   Data_Read      FIFO pop strobe
//   Bus_req        bus request to the CPU arbiter
//   Bus_grant      bus grant from the CPU arbiter
//   Cs, Wena       RAM chip select / write enable
//   Address        RAM write address
//   Databus        RAM write data
//   Dma_End        one-cycle end-of-burst pulse
//   Dma_Partial    registered; last burst ended before NBYTES bytes
//   Byte_Count     registered; bytes written in the last completed burst
//   dbg_state      current FSM state encoding, for observation only
module dma_rx_burst #(
    parameter int                NBYTES    = 3,
    parameter int                ADDR_W    = 8,
    parameter int                DATA_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                CNT_W     = $clog2(NBYTES + 1)
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Ena,
    input  logic [DATA_W-1:0] RX_Data,
    input  logic              RX_Full,
    input  logic              RX_Empty,
    output logic              Data_Read,
    output logic              Bus_req,
    input  logic              Bus_grant,
    output logic              Cs,
    output logic              Wena,
    output logic [ADDR_W-1:0] Address,
    output logic [DATA_W-1:0] Databus,
    output logic              Dma_End,
    output logic              Dma_Partial,
    output logic [CNT_W-1:0]  Byte_Count,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        READ  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBYTES - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NBYTES);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] idx;        // index of the byte being moved
    logic             active;     // engine allowed to drive anything
    logic             last_byte;  // current byte completes a full burst
    logic             rx_full_unused;

    // The FIFO full flag is reserved for a future flow-control feature.
    assign rx_full_unused = RX_Full;

    // Gating with Rst_n makes every strobe drop the moment reset is
    // asserted, without waiting for the state register to be seen.
    assign active    = Rst_n & Ena;
    assign last_byte = (idx == LAST_IDX);
    assign dbg_state = state;

    // ------------------------------------------------------------------
    // Bus, FIFO and RAM strobes. These depend on Bus_grant and RX_Empty in
    // the same cycle, so they are decoded from state plus inputs.
    // ------------------------------------------------------------------
    always_comb begin
        Data_Read = 1'b0;
        Bus_req   = 1'b0;
        Cs        = 1'b0;
        Wena      = 1'b0;
        Address   = '0;
        Databus   = '0;
        Dma_End   = 1'b0;
        if (active) begin
            unique case (state)
                IDLE: begin
                    Bus_req = !RX_Empty;
                end
                REQ: begin
                    Bus_req = 1'b1;
                end
                READ: begin
                    Bus_req   = 1'b1;
                    Data_Read = Bus_grant;
                end
                WRITE: begin
                    Bus_req = 1'b1;
                    if (Bus_grant) begin
                        Cs      = 1'b1;
                        Wena    = 1'b1;
                        Address = BASE_ADDR + ADDR_W'(idx);
                        Databus = RX_Data;
                        // Early end: the FIFO ran dry before a full burst.
                        if (!last_byte && RX_Empty) begin
                            Dma_End = 1'b1;
                        end
                    end
                end
                DONE: begin
                    Dma_End = 1'b1;
                end
                default: begin
                    Bus_req = 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Control FSM. With Ena low everything holds so a frozen burst resumes
    // exactly where it stopped. Byte_Count/Dma_Partial change only in the
    // cycle that raises Dma_End.
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            Byte_Count  <= '0;
            Dma_Partial <= 1'b0;
        end else if (Ena) begin
            unique case (state)
                IDLE: begin
                    idx <= '0;
                    if (!RX_Empty) begin
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (Bus_grant) begin
                        state <= READ;
                    end
                end
                READ: begin
                    // RX_Empty is deliberately ignored here; the check was
                    // already made before entering READ.
                    if (Bus_grant) begin
                        state <= WRITE;
                    end
                end
                WRITE: begin
                    // Without grant the popped byte waits on RX_Data.
                    if (Bus_grant) begin
                        if (last_byte) begin
                            state <= DONE;
                        end else if (!RX_Empty) begin
                            idx   <= idx + ONE;
                            state <= READ;
                        end else begin
                            Byte_Count  <= idx + ONE;
                            Dma_Partial <= 1'b1;
                            state       <= IDLE;
                        end
                    end
                end
                DONE: begin
                    Byte_Count  <= FULL_CNT;
                    Dma_Partial <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
